// File: rtl/alu_issuer_pkg.sv
// Shared constants, types and FSM states for the ALU request issuer.
package alu_issuer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned OPS_W   = 16;

  localparam logic [OPS_W-1:0] OPS_MAX = '1;

  // ALU control codes understood by the external ALU
  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_NOR = 4'b1100;

  // ALUOp encodings; 2'b11 is reserved and therefore illegal
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

  // R-type funct encodings
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Response payload held while waiting for the consumer
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              cout;
    logic              overflow;
    logic              illegal;
  } rsp_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct to ALU control decoder with illegal-op detection.
module alu_ctrl_dec
  import alu_issuer_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               illegal
);

  // Map the request opcode to an ALU control code; unknown encodings flag illegal
  always_comb begin
    ctrl    = CTRL_AND;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_SLT: ctrl = CTRL_SLT;
          FUNCT_NOR: ctrl = CTRL_NOR;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issuer.sv
// Issues one decoded operation at a time to an external ALU and returns its
// result through a valid/ready response channel.
module alu_issuer
  import alu_issuer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [ALUOP_W-1:0] req_aluop_i,
  input  logic [FUNCT_W-1:0] req_funct_i,
  input  logic [DATA_W-1:0]  req_src1_i,
  input  logic [DATA_W-1:0]  req_src2_i,
  output logic               alu_rst_n_o,
  output logic [DATA_W-1:0]  alu_src1_o,
  output logic [DATA_W-1:0]  alu_src2_o,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  input  logic               alu_zero_i,
  input  logic               alu_cout_i,
  input  logic               alu_overflow_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [DATA_W-1:0]  rsp_result_o,
  output logic               rsp_zero_o,
  output logic               rsp_cout_o,
  output logic               rsp_overflow_o,
  output logic               rsp_illegal_o,
  output logic [OPS_W-1:0]   ops_done_o
);

  state_e            state_q;
  rsp_t              rsp_q;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              req_fire;
  logic              rsp_fire;

  alu_ctrl_dec u_dec (
    .aluop   (req_aluop_i),
    .funct   (req_funct_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Handshakes; ready is only ever high in IDLE and valid only in RESP
  assign req_fire = req_valid_i & req_ready_o;
  assign rsp_fire = rsp_valid_o & rsp_ready_i;

  // Response outputs come straight from the held payload register
  assign rsp_result_o   = rsp_q.result;
  assign rsp_zero_o     = rsp_q.zero;
  assign rsp_cout_o     = rsp_q.cout;
  assign rsp_overflow_o = rsp_q.overflow;
  assign rsp_illegal_o  = rsp_q.illegal;

  // Issue FSM: accept in IDLE, one EXEC cycle for the ALU, hold in RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_q       <= '0;
      alu_rst_n_o <= 1'b0;
      alu_src1_o  <= '0;
      alu_src2_o  <= '0;
      alu_ctrl_o  <= CTRL_AND;
      ops_done_o  <= '0;
    end else begin
      alu_rst_n_o <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_fire) begin
            req_ready_o <= 1'b0;
            if (dec_illegal) begin
              // ALU is left untouched; answer directly with a zeroed payload
              rsp_q         <= '0;
              rsp_q.illegal <= 1'b1;
              rsp_valid_o   <= 1'b1;
              state_q       <= ST_RESP;
            end else begin
              alu_src1_o <= req_src1_i;
              alu_src2_o <= req_src2_i;
              alu_ctrl_o <= dec_ctrl;
              state_q    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_q.result   <= alu_result_i;
          rsp_q.zero     <= alu_zero_i;
          rsp_q.cout     <= alu_cout_i;
          rsp_q.overflow <= alu_overflow_i;
          rsp_q.illegal  <= 1'b0;
          rsp_valid_o    <= 1'b1;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state_q     <= ST_IDLE;
            if (!rsp_q.illegal && (ops_done_o != OPS_MAX)) begin
              ops_done_o <= ops_done_o + OPS_W'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_o <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural ALU and a reference model.
module tb_alu_issuer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_aluop_i;
  logic [5:0]  req_funct_i;
  logic [31:0] req_src1_i;
  logic [31:0] req_src2_i;
  logic        alu_rst_n_o;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        alu_cout_i;
  logic        alu_overflow_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_zero_o;
  logic        rsp_cout_o;
  logic        rsp_overflow_o;
  logic        rsp_illegal_o;
  logic [15:0] ops_done_o;

  alu_issuer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_aluop_i    (req_aluop_i),
    .req_funct_i    (req_funct_i),
    .req_src1_i     (req_src1_i),
    .req_src2_i     (req_src2_i),
    .alu_rst_n_o    (alu_rst_n_o),
    .alu_src1_o     (alu_src1_o),
    .alu_src2_o     (alu_src2_o),
    .alu_ctrl_o     (alu_ctrl_o),
    .alu_result_i   (alu_result_i),
    .alu_zero_i     (alu_zero_i),
    .alu_cout_i     (alu_cout_i),
    .alu_overflow_i (alu_overflow_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_zero_o     (rsp_zero_o),
    .rsp_cout_o     (rsp_cout_o),
    .rsp_overflow_o (rsp_overflow_o),
    .rsp_illegal_o  (rsp_illegal_o),
    .ops_done_o     (ops_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        ill;
  } exp_rsp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        co;
    logic        ov;
    logic        ill;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {illegal, ctrl} from the opcode table
  function automatic logic [4:0] exp_decode(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 5'b0_0010;
      2'b01: return 5'b0_0110;
      2'b10: begin
        case (f)
          6'h20:   return 5'b0_0010;
          6'h22:   return 5'b0_0110;
          6'h24:   return 5'b0_0000;
          6'h25:   return 5'b0_0001;
          6'h2A:   return 5'b0_0111;
          6'h27:   return 5'b0_1100;
          default: return 5'b1_0000;
        endcase
      end
      default: return 5'b1_0000;
    endcase
  endfunction

  // Arithmetic meaning of each ALU control code
  function automatic exp_rsp_t alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        co;
    logic        ov;
    r  = 32'd0;
    co = 1'b0;
    ov = 1'b0;
    s  = 33'd0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = 32'd0;
    endcase
    return '{result: r, zero: (r == 32'd0), cout: co, ovf: ov, ill: 1'b0};
  endfunction

  // Behavioural ALU connected to the issuer
  exp_rsp_t alu_out;
  always_comb begin
    alu_out = alu_ref(alu_ctrl_o, alu_src1_o, alu_src2_o);
    if (!alu_rst_n_o) alu_out = '0;
  end
  assign alu_result_i   = alu_out.result;
  assign alu_zero_i     = alu_out.zero;
  assign alu_cout_i     = alu_out.cout;
  assign alu_overflow_i = alu_out.ovf;

  // Reference model: one outstanding operation, answer known at acceptance
  logic [4:0]  m_dec;
  exp_rsp_t    m_now;
  logic        m_ready, m_valid, m_exec, m_en;
  exp_rsp_t    m_rsp, m_pend;
  logic [31:0] m_src1, m_src2;
  logic [3:0]  m_ctrl;
  logic [15:0] m_ops;

  assign m_dec = exp_decode(req_aluop_i, req_funct_i);
  assign m_now = alu_ref(m_dec[3:0], req_src1_i, req_src2_i);

  always @(posedge clk) begin
    if (rst_i) begin
      m_ready <= 1'b0;
      m_valid <= 1'b0;
      m_exec  <= 1'b0;
      m_en    <= 1'b0;
      m_rsp   <= '0;
      m_pend  <= '0;
      m_src1  <= 32'd0;
      m_src2  <= 32'd0;
      m_ctrl  <= 4'd0;
      m_ops   <= 16'd0;
    end else begin
      m_en <= 1'b1;
      if (m_ready && req_valid_i) begin
        m_ready <= 1'b0;
        if (m_dec[4]) begin
          m_rsp   <= '{result: 32'd0, zero: 1'b0, cout: 1'b0, ovf: 1'b0, ill: 1'b1};
          m_valid <= 1'b1;
        end else begin
          m_src1 <= req_src1_i;
          m_src2 <= req_src2_i;
          m_ctrl <= m_dec[3:0];
          m_pend <= m_now;
          m_exec <= 1'b1;
        end
      end else if (m_exec) begin
        m_exec  <= 1'b0;
        m_rsp   <= m_pend;
        m_valid <= 1'b1;
      end else if (m_valid && rsp_ready_i) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
        if (!m_rsp.ill && m_ops != 16'hFFFF) m_ops <= m_ops + 16'd1;
      end else if (!m_valid) begin
        m_ready <= 1'b1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready_o), 32'(m_ready));
      check("rsp_valid", 32'(rsp_valid_o), 32'(m_valid));
      check("alu_rst_n", 32'(alu_rst_n_o), 32'(m_en));
      check("alu_src1", alu_src1_o, m_src1);
      check("alu_src2", alu_src2_o, m_src2);
      check("alu_ctrl", 32'(alu_ctrl_o), 32'(m_ctrl));
      check("rsp_result", rsp_result_o, m_rsp.result);
      check("rsp_zero", 32'(rsp_zero_o), 32'(m_rsp.zero));
      check("rsp_cout", 32'(rsp_cout_o), 32'(m_rsp.cout));
      check("rsp_overflow", 32'(rsp_overflow_o), 32'(m_rsp.ovf));
      check("rsp_illegal", 32'(rsp_illegal_o), 32'(m_rsp.ill));
      check("ops_done", 32'(ops_done_o), 32'(m_ops));
    end
  end

  // Present a request from a negedge; returns at the negedge after acceptance
  task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, output int acc);
    int n;
    req_valid_i = 1'b1;
    req_aluop_i = op;
    req_funct_i = f;
    req_src1_i  = a;
    req_src2_i  = b;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) check("req_accept_timeout", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    acc         = cyc;
    req_valid_i = 1'b0;
    req_aluop_i = 2'($urandom);
    req_funct_i = 6'($urandom);
    req_src1_i  = $urandom;
    req_src2_i  = $urandom;
  endtask

  // Wait for the response, optionally stall it, then accept it
  task automatic get_rsp(input int acc, input int exp_lat, input int hold, output exp_rsp_t r);
    int n;
    n = 0;
    while (!rsp_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_o) check("rsp_valid_timeout", 32'(rsp_valid_o), 32'd1);
    check("latency_edges", 32'(cyc - acc + 1), 32'(exp_lat));
    r = '{result: rsp_result_o, zero: rsp_zero_o, cout: rsp_cout_o,
          ovf: rsp_overflow_o, ill: rsp_illegal_o};
    for (int i = 0; i < hold; i++) begin
      req_valid_i = 1'b1;
      req_aluop_i = 2'($urandom);
      req_funct_i = 6'($urandom);
      req_src1_i  = $urandom;
      req_src2_i  = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid_o), 32'd1);
      check("hold_ready", 32'(req_ready_o), 32'd0);
      check("hold_result", rsp_result_o, r.result);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_xfer", 32'(rsp_valid_o), 32'd0);
  endtask

  vec_t vecs [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int       acc;
    int       ops_exp;
    exp_rsp_t r;

    vecs[0]  = '{2'b00, 6'h00, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 6'h2A, 32'hFFFFFFFF,   32'd1,          4'b0111, 32'd1,          1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 6'h00, 32'h80000000,   32'd1,          4'b0110, 32'h7FFFFFFF,   1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 6'h00, 32'd9,          32'd9,          4'b0110, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 6'h20, 32'd1,          32'd2,          4'b0000, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'b10, 6'h24, 32'hF0F01234,   32'h0FF0FF00,   4'b0000, 32'h00F01200,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'h25, 32'hF0F01234,   32'h0FF0FF00,   4'b0001, 32'hFFF0FF34,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 6'h27, 32'hF0F01234,   32'h0FF0FF00,   4'b1100, 32'h000F00CB,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 6'h20, 32'hFFFFFFFF,   32'd1,          4'b0010, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 6'h22, 32'd3,          32'd5,          4'b0110, 32'hFFFFFFFE,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 6'h00, 32'd3,          32'd4,          4'b0000, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{2'b10, 6'h2A, 32'd5,          32'hFFFFFFFF,   4'b0111, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0};

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_aluop_i = 2'b00;
    req_funct_i = 6'd0;
    req_src1_i  = 32'd0;
    req_src2_i  = 32'd0;
    rsp_ready_i = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_alu_rst_n", 32'(alu_rst_n_o), 32'd0);
    check("rst_ops_done", 32'(ops_done_o), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    check("rst_rsp_result", rsp_result_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready_o), 32'd1);
    check("post_rst_alu_rst_n", 32'(alu_rst_n_o), 32'd1);

    // Directed operation table
    ops_exp = 0;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].funct, vecs[i].a, vecs[i].b, acc);
      if (!vecs[i].ill) check("vec_alu_ctrl", 32'(alu_ctrl_o), 32'(vecs[i].ctrl));
      get_rsp(acc, vecs[i].ill ? 1 : 2, 0, r);
      check("vec_result", r.result, vecs[i].res);
      check("vec_zero", 32'(r.zero), 32'(vecs[i].z));
      check("vec_cout", 32'(r.cout), 32'(vecs[i].co));
      check("vec_overflow", 32'(r.ovf), 32'(vecs[i].ov));
      check("vec_illegal", 32'(r.ill), 32'(vecs[i].ill));
      if (!vecs[i].ill) ops_exp++;
      check("vec_ops_done", 32'(ops_done_o), 32'(ops_exp));
    end

    // Backpressure with request-side noise
    send(2'b00, 6'h00, 32'd100, 32'd23, acc);
    get_rsp(acc, 2, 5, r);
    check("bp_result", r.result, 32'd123);
    check("bp_req_ready_after", 32'(req_ready_o), 32'd1);
    check("bp_ops_done", 32'(ops_done_o), 32'(ops_exp + 1));

    // Reset while in EXEC
    send(2'b00, 6'h00, 32'd1, 32'd1, acc);
    rst_i = 1'b1;
    @(negedge clk);
    check("exec_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("exec_rst_ops_done", 32'(ops_done_o), 32'd0);
    check("exec_rst_alu_rst_n", 32'(alu_rst_n_o), 32'd0);
    check("exec_rst_rsp_result", rsp_result_o, 32'd0);
    check("exec_rst_alu_src1", alu_src1_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    check("exec_rst_req_ready", 32'(req_ready_o), 32'd1);
    check("exec_rst_rsp_valid_after", 32'(rsp_valid_o), 32'd0);

    // Recovery after the aborted operation
    send(2'b00, 6'h00, 32'd2, 32'd3, acc);
    get_rsp(acc, 2, 0, r);
    check("recover_result", r.result, 32'd5);
    check("recover_ops_done", 32'(ops_done_o), 32'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk_i  in  1  single clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_aluop_i  in  2  ALUOp: 00 add, 01 sub, 10 R-type (use funct), 11 reserved
- req_funct_i  in  6  R-type funct field
- req_src1_i, req_src2_i  in  32 each  operands
- alu_rst_n_o  out  1  ALU enable, active-low reset to the ALU
- alu_src1_o, alu_src2_o  out  32 each  operands driven to the ALU
- alu_ctrl_o  out  4  ALU control code
- alu_result_i  in  32  ALU result
- alu_zero_i, alu_cout_i, alu_overflow_i  in  1 each  ALU flags
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer accepts the response
- rsp_result_o  out  32  captured result
- rsp_zero_o, rsp_cout_o, rsp_overflow_o  out  1 each  captured flags
- rsp_illegal_o  out  1  request was not decodable
- ops_done_o  out  16  count of completed legal operations, saturating

Function
REQ-002 The block SHALL transfer a request when req_valid_i and req_ready_o are both 1 on a rising edge, and a response when rsp_valid_o and rsp_ready_i are both 1.
REQ-003 The FSM SHALL have the states IDLE, EXEC and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-004 IDLE SHALL move to EXEC on a legal request transfer and to RESP on an illegal request transfer; with no transfer it SHALL stay in IDLE.
REQ-005 On a legal transfer the block SHALL register the operands into alu_src1_o and alu_src2_o and the decoded code into alu_ctrl_o, and SHALL hold all three stable through EXEC.
REQ-006 EXEC SHALL last exactly one cycle; at its closing edge the block SHALL capture alu_result_i and the three ALU flags into the rsp_* registers, clear rsp_illegal_o, and move to RESP.
REQ-007 RESP SHALL hold rsp_valid_o at 1 and all rsp_* values stable until the response transfers, then return to IDLE; rsp_valid_o SHALL be 0 in IDLE and EXEC.
REQ-008 Latency SHALL be as follows: for a request transferred at edge N, rsp_valid_o SHALL be 1 from cycle N+2 if the request is legal and from cycle N+1 if it is illegal.
REQ-009 Decode for ALUOp 00 SHALL give 0010; ALUOp 01 SHALL give 0110.
REQ-010 Decode for ALUOp 10 with funct 100000, 100010, 100100, 100101, 101010, 100111 SHALL give 0010, 0110, 0000, 0001, 0111, 1100 respectively.
REQ-011 ALUOp 11, or ALUOp 10 with any other funct, SHALL be illegal: the ALU SHALL not be driven, and the response SHALL carry rsp_illegal_o=1, rsp_result_o=0 and all flags 0.
REQ-012 ops_done_o SHALL increment by 1 on each legal response transfer and saturate at 16'hFFFF; illegal responses SHALL not count.
REQ-013 Because a new request is accepted only in IDLE, a request and a response SHALL never transfer in the same cycle.
REQ-014 Request inputs outside a transfer SHALL be ignored, and changes to them during EXEC or RESP SHALL not affect the ALU drive or the response.

Reset
REQ-015 While rst_i is 1 at an edge, the block SHALL enter IDLE with:
- req_ready_o=0 during reset
- rsp_valid_o=0
- all rsp_* outputs 0
- alu_src1_o=0, alu_src2_o=0, alu_ctrl_o=4'b0000
- ops_done_o=0
- alu_rst_n_o=0
REQ-016 In the first cycle after rst_i deasserts, alu_rst_n_o SHALL be 1 and req_ready_o SHALL be 1.
REQ-017 A reset asserted in EXEC or RESP SHALL abort the operation and drop any pending response with no partial output.

Structure
REQ-018 A shared package SHALL hold the ALU control codes (AND, OR, ADD, SUB, SLT, NOR), the ALUOp and funct constants, and the FSM state enumeration.
REQ-019 Decoding SHALL live in one combinational sub-module, alu_ctrl_dec, with inputs aluop and funct and outputs ctrl[3:0] and illegal.
REQ-020 The ALU SHALL be external to this block, connected through the alu_* ports.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, using the connected 32-bit ALU:
- Add: aluop=00, src1=5, src2=7 -> alu_ctrl_o=0010, rsp_result_o=12, zero=0, rsp_valid_o at N+2, ops_done_o=1.
- SLT: aluop=10, funct=101010, src1=32'hFFFFFFFF, src2=1 -> alu_ctrl_o=0111, rsp_result_o=1.
- Sub overflow: aluop=01, src1=32'h80000000, src2=1 -> rsp_result_o=32'h7FFFFFFF, rsp_overflow_o=1; and src1=src2=9 -> rsp_zero_o=1.
- Illegal: aluop=11 -> rsp_illegal_o=1, rsp_result_o=0, rsp_valid_o at N+1, ops_done_o unchanged.
- Backpressure: rsp_ready_i held 0 for 5 cycles -> response stable, req_ready_o=0, operand changes on req_* ignored; the response transfers on the first cycle rsp_ready_i=1.
- Reset in EXEC: rst_i=1 for one cycle -> next cycle rsp_valid_o=0, ops_done_o=0, alu_rst_n_o=0; after release, req_ready_o=1.
